// File: rtl/cpu_pipe_q.sv
// rtl/cpu_pipe_q.sv - multicycle 16-bit ISA CPU with instruction queue and parametrised datapath
`timescale 1ns/1ps
module cpu_pipe_q #(
    parameter int DATA_W   = 16,
    parameter int IQ_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             instr_valid,
    output logic                             instr_ready,
    input  logic [15:0]                      instr,
    output logic                             waiting,
    output logic [DATA_W-1:0]                out,
    output logic                             N,
    output logic                             V,
    output logic                             Z,
    output logic                             illegal,
    output logic [$clog2(IQ_DEPTH+1)-1:0]    iq_count
);
    localparam int CW = $clog2(IQ_DEPTH + 1);
    localparam int PW = $clog2(IQ_DEPTH);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       iq_mem_q [IQ_DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ready_q;
    logic              push, pop;

    logic [15:0]       ir_q;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic              n_q, v_q, z_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(IQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ready is a register, so a pop never frees a slot for a push in the same cycle
    assign push = instr_valid && ready_q;
    assign pop  = (state_q == S_WAIT) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            ready_q  <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != CW'(IQ_DEPTH));
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) iq_mem_q[wr_ptr_q] <= instr;
    end

    logic [2:0]        op, rn, rd, rm;
    logic [1:0]        sub, sh;
    logic [DATA_W-1:0] sximm8, b_sh, diff;
    logic              is_movi, is_movr, is_add, is_cmp, is_and, is_mvn;

    assign op      = ir_q[15:13];
    assign sub     = ir_q[12:11];
    assign rn      = ir_q[10:8];
    assign rd      = ir_q[7:5];
    assign sh      = ir_q[4:3];
    assign rm      = ir_q[2:0];
    assign sximm8  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign is_movi = (op == 3'b110) && (sub == 2'b10);
    assign is_movr = (op == 3'b110) && (sub == 2'b00);
    assign is_add  = (op == 3'b101) && (sub == 2'b00);
    assign is_cmp  = (op == 3'b101) && (sub == 2'b01);
    assign is_and  = (op == 3'b101) && (sub == 2'b10);
    assign is_mvn  = (op == 3'b101) && (sub == 2'b11);

    always_comb begin
        b_sh = b_q;
        case (sh)
            2'b01:   b_sh = {b_q[DATA_W-2:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[DATA_W-1:1]};
            2'b11:   b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
            default: b_sh = b_q;
        endcase
    end

    assign diff = a_q - b_sh;

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_WAIT:   if (pop) state_d = S_DECODE;
            S_DECODE: begin
                if (is_movi) begin
                    state_d = S_WRITE;
                end else if (is_movr || is_mvn) begin
                    state_d = S_GET_B;
                end else if (is_add || is_cmp || is_and) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_WAIT;
                    illegal = 1'b1;
                end
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = is_cmp ? S_WAIT : S_WRITE;
            S_WRITE:  state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            n_q  <= 1'b0;
            v_q  <= 1'b0;
            z_q  <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            if (pop) ir_q <= iq_mem_q[rd_ptr_q];
            case (state_q)
                S_GET_A: a_q <= regs_q[rn];
                S_GET_B: b_q <= regs_q[rm];
                S_EXEC: begin
                    if (is_cmp) begin
                        n_q <= diff[DATA_W-1];
                        z_q <= (diff == '0);
                        // overflow when operand signs differ and the result sign leaves A's
                        v_q <= (a_q[DATA_W-1] != b_sh[DATA_W-1]) &&
                               (diff[DATA_W-1] != a_q[DATA_W-1]);
                    end else if (is_add) begin
                        c_q <= a_q + b_sh;
                    end else if (is_and) begin
                        c_q <= a_q & b_sh;
                    end else if (is_mvn) begin
                        c_q <= ~b_sh;
                    end else begin
                        c_q <= b_sh;
                    end
                end
                S_WRITE: begin
                    if (is_movi) begin
                        regs_q[rn] <= sximm8;
                    end else begin
                        regs_q[rd] <= c_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign iq_count    = count_q;
    assign waiting     = (state_q == S_WAIT);
    assign out         = c_q;
    assign N           = n_q;
    assign V           = v_q;
    assign Z           = z_q;
endmodule

// File: tb/tb_cpu_pipe_q.sv
// tb/tb_cpu_pipe_q.sv - directed table plus randomized model-checked bench for cpu_pipe_q
`timescale 1ns/1ps
module tb_cpu_pipe_q;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [15:0]   instr = 16'h0000;
    logic          instr_ready, waiting, N, V, Z, illegal;
    logic [DW-1:0] out;
    logic [CW-1:0] iq_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_pipe_q #(.DATA_W(DW), .IQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .waiting(waiting), .out(out), .N(N), .V(V), .Z(Z),
        .illegal(illegal), .iq_count(iq_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: architectural state only, evaluated per instruction with integer arithmetic
    logic [DW-1:0] m_regs [8];
    logic [DW-1:0] m_out;
    logic          m_n, m_v, m_z;
    logic [15:0]   model_q [$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_out = '0; m_n = 0; m_v = 0; m_z = 0;
        model_q.delete();
    endtask

    task automatic model_exec(input logic [15:0] w);
        longint full = longint'(1) << DW;
        longint half = longint'(1) << (DW - 1);
        longint a, b, r, sa, sb, sd, imm;
        a = longint'(m_regs[w[10:8]]);
        b = longint'(m_regs[w[2:0]]);
        case (w[4:3])
            2'b01:   b = (b * 2) % full;
            2'b10:   b = b / 2;
            2'b11:   b = b / 2 + ((b >= half) ? half : 0);
            default: ;
        endcase
        case (w[15:11])
            5'b11010: begin
                imm = longint'(w[7:0]);
                if (imm >= 128) imm = imm - 256;
                m_regs[w[10:8]] = DW'((imm + full) % full);
            end
            5'b11000: begin m_out = DW'(b); m_regs[w[7:5]] = m_out; end
            5'b10100: begin m_out = DW'((a + b) % full); m_regs[w[7:5]] = m_out; end
            5'b10110: begin m_out = DW'(a & b); m_regs[w[7:5]] = m_out; end
            5'b10111: begin m_out = DW'(full - 1 - b); m_regs[w[7:5]] = m_out; end
            5'b10101: begin
                sa = (a >= half) ? a - full : a;
                sb = (b >= half) ? b - full : b;
                sd = sa - sb;
                r  = (a - b + full) % full;
                m_n = (r >= half);
                m_z = (r == 0);
                m_v = (sd < -half) || (sd >= half);
            end
            default: ;
        endcase
    endtask

    function automatic logic [15:0] gen_word(input bit only_add);
        logic [15:0] w;
        int k;
        w = 16'($urandom);
        k = only_add ? 2 : $urandom_range(0, 9);
        case (k)
            0, 1:    w[15:11] = 5'b11010;
            2:       w[15:11] = 5'b10100;
            3:       w[15:11] = 5'b10110;
            4:       w[15:11] = 5'b10101;
            5:       w[15:11] = 5'b10111;
            6, 7:    w[15:11] = 5'b11000;
            default: w[15:13] = 3'($urandom_range(0, 4));
        endcase
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic compare_model(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s_R%0d", tag, i), dut.regs_q[i], m_regs[i]);
        check({tag, "_out"}, out, m_out);
        check({tag, "_nvz"}, {N, V, Z}, {m_n, m_v, m_z});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(waiting && iq_count == 0) && n < 1000);
        check({tag, "_drain_done"}, (waiting && iq_count == 0), 1);
        while (model_q.size() > 0) model_exec(model_q.pop_front());
    endtask

    // Producer holds each word until it is handshaked; queue occupancy is tracked from push/pop rules
    task automatic stream(input int n_instr, input bit always_valid, input bit only_add);
        int sent = 0, cyc = 0, exp_cnt = 0;
        bit have = 0, prev_push = 0, prev_pop = 0, saw_full = 0;
        @(negedge clk);
        while (sent < n_instr && cyc < 4000) begin
            exp_cnt = exp_cnt + int'(prev_push) - int'(prev_pop);
            check("iq_count", iq_count, exp_cnt);
            check("instr_ready", instr_ready, (exp_cnt < DEPTH));
            if (prev_pop) check("pop_leaves_wait", waiting, 0);
            if (!instr_ready) saw_full = 1;
            prev_pop = waiting && (exp_cnt > 0);
            if (!have) begin
                if (always_valid || $urandom_range(0, 2) != 0) begin
                    instr = gen_word(only_add);
                    instr_valid = 1'b1;
                    have = 1;
                end else begin
                    instr_valid = 1'b0;
                end
            end
            prev_push = have && instr_ready;
            if (prev_push) begin
                model_q.push_back(instr);
                sent++;
                have = 0;
            end
            @(negedge clk);
            cyc++;
        end
        instr_valid = 1'b0;
        check("stream_sent", sent, n_instr);
        if (always_valid) check("backpressure_seen", saw_full, 1);
    endtask

    typedef struct {
        logic [15:0] w;
        int          lat;
        logic [15:0] out_e;
        logic [2:0]  nvz;
        int          ridx;
        logic [15:0] reg_e;
        int          ill;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int lat, ill;
        tbl[0]  = '{16'hD007, 2, 16'h0000, 3'b000, 0, 16'h0007, 0};
        tbl[1]  = '{16'hD102, 2, 16'h0000, 3'b000, 1, 16'h0002, 0};
        tbl[2]  = '{16'hA049, 5, 16'h000B, 3'b000, 2, 16'h000B, 0};
        tbl[3]  = '{16'hA800, 4, 16'h000B, 3'b001, 0, 16'h0007, 0};
        tbl[4]  = '{16'hD5FF, 2, 16'h000B, 3'b001, 5, 16'hFFFF, 0};
        tbl[5]  = '{16'hC0D5, 4, 16'h7FFF, 3'b001, 6, 16'h7FFF, 0};
        tbl[6]  = '{16'hAE05, 4, 16'h7FFF, 3'b110, 6, 16'h7FFF, 0};
        tbl[7]  = '{16'h0000, 1, 16'h7FFF, 3'b110, 0, 16'h0007, 1};
        tbl[8]  = '{16'hB861, 4, 16'hFFFD, 3'b110, 3, 16'hFFFD, 0};
        tbl[9]  = '{16'hB589, 5, 16'h0004, 3'b110, 4, 16'h0004, 0};
        tbl[10] = '{16'hC0FE, 4, 16'h3FFF, 3'b110, 7, 16'h3FFF, 0};
        tbl[11] = '{16'hE000, 1, 16'h3FFF, 3'b110, 7, 16'h3FFF, 1};
        tbl[12] = '{16'hA903, 4, 16'h3FFF, 3'b000, 1, 16'h0002, 0};
        tbl[13] = '{16'hA501, 5, 16'h0001, 3'b000, 0, 16'h0001, 0};

        #12;
        check("rst_waiting", waiting, 1);
        check("rst_iq_count", iq_count, 0);
        check("rst_ready", instr_ready, 1);
        check("rst_out", out, 0);
        check("rst_nvz", {N, V, Z}, 0);
        check("rst_illegal", illegal, 0);
        check("rst_R7", dut.regs_q[7], 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            instr = tbl[i].w;
            instr_valid = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
            lat = 0;
            ill = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (illegal) ill++;
                if (!waiting) lat++;
                else if (lat > 0) break;
            end
            check($sformatf("row%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("row%0d_illegal", i), ill, tbl[i].ill);
            check($sformatf("row%0d_out", i), out, tbl[i].out_e);
            check($sformatf("row%0d_nvz", i), {N, V, Z}, tbl[i].nvz);
            check($sformatf("row%0d_reg", i), dut.regs_q[tbl[i].ridx], tbl[i].reg_e);
        end

        // Reset during EXEC of an ADD with two more instructions queued
        @(negedge clk);
        instr = 16'hA049; instr_valid = 1'b1;
        @(negedge clk);
        instr = 16'hD0AA;
        @(negedge clk);
        instr = 16'hD1BB;
        @(negedge clk);
        instr_valid = 1'b0;
        check("pre_rst_count", iq_count, 2);
        check("pre_rst_busy", waiting, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_waiting", waiting, 1);
        check("async_count", iq_count, 0);
        check("async_ready", instr_ready, 1);
        check("async_out", out, 0);
        check("async_nvz", {N, V, Z}, 0);
        for (int i = 0; i < 8; i++) check($sformatf("async_R%0d", i), dut.regs_q[i], 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!waiting) lat++;
        end
        check("post_rst_idle", lat, 0);
        check("post_rst_R0", dut.regs_q[0], 0);
        check("post_rst_R1", dut.regs_q[1], 0);

        do_reset();
        stream(80, 1'b0, 1'b0);
        drain("rand");
        compare_model("rand");

        stream(6, 1'b1, 1'b1);
        drain("adds");
        compare_model("adds");

        stream(40, 1'b1, 1'b0);
        drain("burst");
        compare_model("burst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_pipe_q.md
Name: cpu_pipe_q

Overview:
- Parametrised successor to the lab CPU: the same 16-bit multicycle ISA (MOV imm, MOV reg with shift, ADD, CMP, AND, MVN).
- Configurable datapath width.
- Instruction queue with a valid/ready handshake replaces the single load/start instruction register.
- Self-contained: holds its own register file (R0–R7), controller FSM, decoder, shifter, ALU and status flags.

Parameters:
- DATA_W, 16, datapath and register width in bits; legal values are >= 16.
- IQ_DEPTH, 4, instruction queue entries; legal values are >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  an instruction is presented on instr.
- instr_ready  output  1  queue can accept; high when the queue is not full.
- instr  input  16  instruction word.
- waiting  output  1  FSM is in WAIT (idle).
- out  output  DATA_W  C register (last ALU/shifter result).
- N  output  1  negative flag.
- V  output  1  signed overflow flag.
- Z  output  1  zero flag.
- illegal  output  1  high for one cycle when an unsupported opcode is decoded.
- iq_count  output  $clog2(IQ_DEPTH+1)  current queue occupancy.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - FSM goes to WAIT; waiting=1.
  - Queue is emptied; iq_count=0; instr_ready=1.
  - R0–R7, out, N, V and Z are cleared to 0; illegal=0.
  - Any instruction in flight is discarded.
- Push: an instruction is enqueued on a rising edge when instr_valid && instr_ready.
- Pop: happens on an edge while in WAIT with iq_count>0. The head entry loads into IR and the FSM moves to DECODE.
- Push and pop on the same edge leave iq_count unchanged.
- Pop does not free a slot in the same cycle: instr_ready is registered from count, so a full queue stays not-ready for that cycle.
- Instruction fields:
  - op=[15:13], sub=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0].
  - imm8 is sign-extended to DATA_W.
- Shifter applies sh to the B operand only:
  - 00: none.
  - 01: LSL 1.
  - 10: LSR 1, zero fill.
  - 11: ASR 1, MSB replicated.
- FSM states: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE.
- State sequences after DECODE, with cycles out of WAIT:
  - 110/10 MOV Rn,#imm8: WRITE (Rn<=sximm8). 2 cycles. out and flags unchanged.
  - 110/00 MOV Rd,Rm{,sh}: GET_B, EXEC (C<=sh(Rm)), WRITE (Rd<=C). 4 cycles.
  - 101/00 ADD Rd,Rn,Rm{,sh}: GET_A, GET_B, EXEC (C<=Rn+sh(Rm), mod 2^DATA_W), WRITE. 5 cycles.
  - 101/10 AND: same sequence as ADD, with C<=Rn&sh(Rm). 5 cycles.
  - 101/01 CMP Rn,Rm{,sh}: GET_A, GET_B, EXEC (N/V/Z from Rn−sh(Rm)), then WAIT. 4 cycles. C and registers unchanged.
  - 101/11 MVN Rd,Rm{,sh}: GET_B, EXEC (C<=~sh(Rm)), WRITE. 4 cycles.
  - Any other op/sub: illegal=1 during DECODE, then WAIT. 1 cycle. No state change.
- Flag rules:
  - N, V and Z update only at the CMP EXEC edge.
  - V is signed overflow of the subtraction.
- waiting is combinational: state==WAIT.
- Back-to-back: when the queue is non-empty, the next instruction pops on the edge that leaves WAIT, so waiting is high for exactly one cycle between instructions.
- Instructions execute strictly in push order.
- Writes to a register land before the next instruction's GET_A/GET_B, so there are no hazards.
- Pushes during execution are accepted while instr_ready=1.
- Valid with instr_ready=0: the instruction is not taken. The producer holds it and the block never drops a handshaked instruction.

Test Plan:
- Reset, then push 0xD007 (MOV R0,#7), 0xD102 (MOV R1,#2), 0xA049 (ADD R2,R0,R1 LSL1) -> R2=0x000B, out=0x000B, N=V=Z=0, each instruction finishing at the stated latency.
- With R0=7, push 0xA800 (CMP R0,R0) -> Z=1, N=0, V=0, out unchanged.
- Push 0xD5FF, 0xC0D5 (MOV R6,R5 LSR), 0xAE05 (CMP R6,R5) -> R5=0xFFFF, R6=0x7FFF, N=1, V=1, Z=0.
- IQ_DEPTH=2: hold instr_valid high with six ADDs, one per cycle -> instr_ready drops when iq_count=2, no push while low, all six retire in order, final register values match the reference model.
- Push 0x0000 -> illegal pulses exactly one cycle, R0–R7/out/flags unchanged, waiting returns high next cycle.
- Deassert rst_n mid-EXEC of an ADD with 2 instructions queued -> waiting=1, iq_count=0, out=0, R0–R7=0 immediately, without waiting for a clock edge; no queued instruction executes after release.
